// File: rtl/lsu_ifetch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// lsu_ifetch_mem_arbiter : one-outstanding arbiter of fetch and LSU onto a
// single memory port, with LSU lane steering. Option: ARB_STARVE_GUARD_EN.
// Rev 1.0
// ============================================================================
module lsu_ifetch_mem_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic        ls_sign_extend,
  input  logic [1:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_I  = 3'd1,
    S_WAIT_I = 3'd2,
    S_REQ_D  = 3'd3,
    S_WAIT_D = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [1:0]  r_ld_off, r_ld_width;
  logic        r_ld_sign;

  logic        w_misaligned, w_fault, w_d_ok, w_sel_d, w_sel_i, w_i_forced;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_ld_data;

  assign w_misaligned = ((ls_width == 2'b01) && ls_addr[0]) ||
                        (ls_width[1] && (ls_addr[1:0] != 2'b00));
  assign w_fault = (r_state == S_IDLE) && ls_req && w_misaligned;
  assign w_d_ok  = ls_req && !w_misaligned;

  // A misaligned D request is answered locally, so it also holds off fetch for that cycle
  assign w_sel_d = (r_state == S_IDLE) && w_d_ok && !w_i_forced;
  assign w_sel_i = (r_state == S_IDLE) && if_req && !w_fault && (w_i_forced || !w_d_ok);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_max_burst = 4'(MAX_D_BURST);
  logic [3:0] r_burst;

  assign w_i_forced = if_req && (r_burst == c_max_burst);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (!if_req || w_sel_i) begin
        r_burst <= 4'd0;
      end else if (w_sel_d) begin
        r_burst <= r_burst + 4'd1;
      end
    end
  end
`else
  assign w_i_forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sel_d) begin
          w_state_nxt = S_REQ_D;
        end else if (w_sel_i) begin
          w_state_nxt = S_REQ_I;
        end
      end
      S_REQ_I:  if (mem_gnt)    w_state_nxt = S_WAIT_I;
      S_WAIT_I: if (mem_rvalid) w_state_nxt = S_IDLE;
      S_REQ_D:  if (mem_gnt)    w_state_nxt = S_WAIT_D;
      S_WAIT_D: if (mem_rvalid) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ls_wdata;
    case (ls_width)
      2'b00: begin
        w_be    = 4'b0001 << ls_addr[1:0];
        w_wdata = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {ls_addr[1], 1'b0};
        w_wdata = {2{ls_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_ld_off    <= 2'd0;
      r_ld_width  <= 2'd0;
      r_ld_sign   <= 1'b0;
    end else if (w_sel_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= ls_we;
      r_mem_addr  <= {ls_addr[31:2], 2'b00};
      r_mem_be    <= w_be;
      r_mem_wdata <= w_wdata;
      r_ld_off    <= ls_addr[1:0];
      r_ld_width  <= ls_width;
      r_ld_sign   <= ls_sign_extend;
    end else if (w_sel_i) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr & 32'hFFFF_FFFC;
      r_mem_be    <= 4'b1111;
      r_mem_wdata <= 32'd0;
    end else if (((r_state == S_REQ_I) || (r_state == S_REQ_D)) && mem_gnt) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Load formatting uses the address latched at issue, not the live LSU inputs
  assign w_shift = mem_rdata >> {r_ld_off, 3'b000};

  always_comb begin
    w_ld_data = w_shift;
    case (r_ld_width)
      2'b00:   w_ld_data = {{24{r_ld_sign & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ld_data = {{16{r_ld_sign & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  assign if_gnt        = (r_state == S_REQ_I) && mem_gnt;
  assign if_rvalid     = (r_state == S_WAIT_I) && mem_rvalid;
  assign if_rdata      = (r_state == S_WAIT_I) ? mem_rdata : 32'd0;

  assign ls_gnt        = ((r_state == S_REQ_D) && mem_gnt) || w_fault;
  assign ls_rvalid     = ((r_state == S_WAIT_D) && mem_rvalid) || w_fault;
  assign ls_misaligned = w_fault;
  assign ls_rdata      = ((r_state == S_WAIT_D) && !r_mem_we) ? w_ld_data : 32'd0;

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_be        = r_mem_be;
  assign mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ifetch_mem_arbiter.sv
`default_nettype none
// tb_lsu_ifetch_mem_arbiter : directed and randomized transactions checked
// against a byte-level reference model of the arbiter's rules.
module tb_lsu_ifetch_mem_arbiter;

  localparam int c_MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0, ls_sign_extend = 1'b0;
  logic [1:0]  ls_width = 2'd0;
  logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
  logic        ls_gnt, ls_rvalid, ls_misaligned;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_ifetch_mem_arbiter #(.MAX_D_BURST(c_MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_sign_extend(ls_sign_extend), .ls_width(ls_width),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_misaligned(ls_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: access size in bytes and lane arithmetic ----
  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] w, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(w)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] w, input logic [1:0] off);
    int n = nbytes(w);
    int start = (n == 4) ? 0 : int'(off) - (int'(off) % n);
    logic [7:0] b;
    b = 8'(((1 << n) - 1) << start);
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
    int n = nbytes(w);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ldata(input logic [1:0] w, input logic sg,
                                          input logic [1:0] off, input logic [31:0] raw);
    int n = nbytes(w);
    int start = (n == 4) ? 0 : int'(off) - (int'(off) % n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = raw[8*(start+k) +: 8];
    if (sg && (n < 4) && v[8*n-1]) begin
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic check_all_zero(input string p);
    check({p, "_ctl"}, {22'd0, mem_req, mem_we, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_misaligned, 3'd0}, 32'd0);
    check({p, "_addr"}, mem_addr, 32'd0);
    check({p, "_be"}, {28'd0, mem_be}, 32'd0);
    check({p, "_wdata"}, mem_wdata, 32'd0);
    check({p, "_if_rdata"}, if_rdata, 32'd0);
    check({p, "_ls_rdata"}, ls_rdata, 32'd0);
  endtask

  // One complete transaction from IDLE; returns what the memory side saw
  task automatic do_txn(input logic is_d, input logic we, input logic [1:0] w, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] raw,
                        input int gw, input int rw,
                        output logic [3:0] o_be, output logic [31:0] o_addr,
                        output logic [31:0] o_wdata, output logic [31:0] o_rdata, output logic o_fault);
    o_be = 'x; o_addr = 'x; o_wdata = 'x; o_rdata = 'x; o_fault = 1'b0;
    if (is_d) begin
      ls_req = 1'b1; ls_we = we; ls_width = w; ls_sign_extend = sg; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    mem_rdata = $urandom;
    @(negedge clk);
    if (is_d && m_mis(w, addr)) begin
      o_fault = ls_misaligned;
      check("fault_gnt", ls_gnt, 1);
      check("fault_rvalid", ls_rvalid, 1);
      check("fault_flag", ls_misaligned, 1);
      check("fault_rdata", ls_rdata, 0);
      check("fault_memreq", mem_req, 0);
      next();
      ls_req = 1'b0;
      @(negedge clk);
      check("fault_stay_idle", mem_req, 0);
      next();
      return;
    end
    check("idle_gnt", is_d ? ls_gnt : if_gnt, 0);
    next();
    for (int k = 0; k <= gw; k++) begin
      mem_gnt    = (k == gw);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      check("req_gnt", is_d ? ls_gnt : if_gnt, (k == gw) ? 1 : 0);
      check("req_mem_req", mem_req, 1);
      if (k == gw) begin
        check("rvalid_in_req", is_d ? ls_rvalid : if_rvalid, 0);
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("mem_we", mem_we, is_d ? we : 1'b0);
        check("mem_be", mem_be, is_d ? m_be(w, addr[1:0]) : 4'hF);
        if (is_d && we) check("mem_wdata", mem_wdata, m_wdata(w, wd));
        o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata;
      end
      next();
    end
    mem_gnt = 1'b0; ls_req = 1'b0; if_req = 1'b0;
    for (int k = 0; k <= rw; k++) begin
      mem_rvalid = (k == rw);
      mem_rdata  = (k == rw) ? raw : $urandom;
      @(negedge clk);
      check("wait_rvalid", is_d ? ls_rvalid : if_rvalid, (k == rw) ? 1 : 0);
      if (k == 0) check("wait_mem_req", mem_req, 0);
      if (k == rw) begin
        o_rdata = is_d ? ls_rdata : if_rdata;
        check("rdata", o_rdata, is_d ? (we ? 32'd0 : m_ldata(w, sg, addr[1:0], raw)) : raw);
      end
      next();
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic        o_fault;
    int          gseq[$];

    repeat (3) next();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    next();

    // zero-wait fetch
    do_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'h0000_0013, 0, 0, o_be, o_addr, o_wdata, o_rdata, o_fault);
    check("fetch_addr", o_addr, 32'h100);
    check("fetch_rdata", o_rdata, 32'h13);

    // signed / unsigned byte load from the top lane
    do_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'd0, 32'h80FF_7F01, 0, 0, o_be, o_addr, o_wdata, o_rdata, o_fault);
    check("sbyte_be", o_be, 4'b1000);
    check("sbyte_rdata", o_rdata, 32'hFFFF_FF80);
    do_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'd0, 32'h80FF_7F01, 1, 2, o_be, o_addr, o_wdata, o_rdata, o_fault);
    check("ubyte_rdata", o_rdata, 32'h0000_0080);

    // half store, upper half
    do_txn(1'b1, 1'b1, 2'b01, 1'b0, 32'h302, 32'hABCD_1234, 32'hDEAD_BEEF, 0, 1, o_be, o_addr, o_wdata, o_rdata, o_fault);
    check("hstore_be", o_be, 4'b1100);
    check("hstore_wdata", o_wdata, 32'h1234_1234);
    check("hstore_addr", o_addr, 32'h300);
    check("hstore_rdata", o_rdata, 32'd0);

    // misaligned word
    do_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h401, 32'd0, 32'd0, 0, 0, o_be, o_addr, o_wdata, o_rdata, o_fault);
    check("misaligned_flag", o_fault, 1);

    // randomized mix of fetches and LSU accesses
    for (int t = 0; t < 40; t++) begin
      logic        d, we_r, sg_r;
      logic [1:0]  w_r;
      logic [31:0] a, wd, raw;
      int          n;
      d    = ($urandom_range(0, 2) != 0);
      we_r = 1'($urandom_range(0, 1));
      sg_r = 1'($urandom_range(0, 1));
      w_r  = 2'($urandom_range(0, 3));
      a    = $urandom & 32'hFFFF_FFFC;
      n    = nbytes(w_r);
      if (!d)                              a = a;
      else if ($urandom_range(0, 3) == 0)  a = a | 32'($urandom_range(0, 3));
      else                                 a = a | 32'(n * $urandom_range(0, 3 / n));
      wd  = $urandom;
      raw = $urandom;
      do_txn(d, d ? we_r : 1'b0, d ? w_r : 2'b10, sg_r, a, wd, raw,
             $urandom_range(0, 2), $urandom_range(0, 2), o_be, o_addr, o_wdata, o_rdata, o_fault);
    end

    // contention: both sides requesting continuously, zero-wait memory
    if_req = 1'b1; if_addr = 32'h500;
    ls_req = 1'b1; ls_we = 1'b0; ls_width = 2'b10; ls_addr = 32'h600;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    for (int c = 0; c < 40 && gseq.size() < 10; c++) begin
      @(negedge clk);
      if (ls_gnt) gseq.push_back(0);
      if (if_gnt) gseq.push_back(1);
      next();
    end
    check("cont_count", gseq.size(), 10);
    for (int k = 0; k < gseq.size(); k++) begin
`ifdef ARB_STARVE_GUARD_EN
      check($sformatf("cont_grant%0d", k), gseq[k], ((k % (c_MAX_BURST + 1)) == c_MAX_BURST) ? 1 : 0);
`else
      check($sformatf("cont_grant%0d", k), gseq[k], 0);
`endif
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (3) next();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    next();

    // reset while waiting for load data
    ls_req = 1'b1; ls_we = 1'b0; ls_width = 2'b10; ls_addr = 32'h700;
    next();
    mem_gnt = 1'b1;
    @(negedge clk);
    check("rstw_gnt", ls_gnt, 1);
    next();
    ls_req = 1'b0; mem_gnt = 1'b0; rst = 1'b1;
    next();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    check("rstw_late_rvalid", ls_rvalid, 0);
    check_all_zero("rstw");
    next();
    @(negedge clk);
    check("rstw_idle_memreq", mem_req, 0);
    mem_rvalid = 1'b0;
    next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
